// File: rtl/fpu_seq_if.sv
// Valid/ready handshake bundle for the sequential FPU: operand/op channel in,
// result/flags channel out.
interface fpu_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [2:0]   flags;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fpu_seq.sv
// Sequential FPU: truncating add/sub via an align/sum/normalise FSM, single-step
// compares, MOV and IEEE special cases, with valid/ready on both sides.
module fpu_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    fpu_seq_if.slave   bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;   // mantissa including hidden bit
    localparam int EW = EXP_W + 2;   // signed working exponent, room for carry and underflow

    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [MAN_W-1:0]     MAN_ZERO = '0;
    localparam logic [W-2:0]         MAG_ZERO = '0;
    localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW-1:0] EXP_ONE  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] EXP_MAX  = {2'b00, EXP_ONES};
    localparam logic [2:0]           FL_INV   = 3'b100;
    localparam logic [2:0]           FL_OVF   = 3'b010;
    localparam logic [2:0]           FL_UNF   = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_SUM, S_NORM, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_SUB = 3'd1, OP_EQ = 3'd2, OP_LT = 3'd3,
        OP_GT  = 3'd4, OP_LE  = 3'd5, OP_GE = 3'd6, OP_MOV = 3'd7
    } op_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [W-1:0]          r_result;
    logic [2:0]            r_flags;
    logic [W-1:0]          r_a;
    logic [W-1:0]          r_b;
    logic [M-1:0]          r_mx;
    logic [M-1:0]          r_my;
    logic [M-1:0]          r_man;
    logic signed [EW-1:0]  r_exp;
    logic                  r_sx;
    logic                  r_sub;
    logic                  r_zero_sign;

    logic [W-1:0]          w_fa;
    logic [W-1:0]          w_fb;
    logic                  w_b_sign;
    logic                  w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic signed [W-1:0]   w_ka, w_kb;
    logic                  w_cmp;
    logic                  w_fast;
    logic [W-1:0]          w_fast_res;
    logic [2:0]            w_fast_fl;
    logic                  w_swap;
    logic [W-1:0]          w_x, w_y;
    logic [EXP_W-1:0]      w_ex, w_ey, w_diff;
    logic [M-1:0]          w_mx, w_my;
    logic [M:0]            w_sum;

    // Input decode: denormals flush to signed zero, SUB folds into b's sign.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_fa = bus.a;
        w_fb = bus.b;
        if (bus.a[W-2:MAN_W] == '0) w_fa = {bus.a[W-1], MAG_ZERO};
        if (bus.b[W-2:MAN_W] == '0) w_fb = {bus.b[W-1], MAG_ZERO};
        w_b_sign = w_fb[W-1] ^ (op_t'(bus.op) == OP_SUB);
        w_a_nan  = (w_fa[W-2:MAN_W] == EXP_ONES) && (w_fa[MAN_W-1:0] != '0);
        w_b_nan  = (w_fb[W-2:MAN_W] == EXP_ONES) && (w_fb[MAN_W-1:0] != '0);
        w_a_inf  = (w_fa[W-2:MAN_W] == EXP_ONES) && (w_fa[MAN_W-1:0] == '0);
        w_b_inf  = (w_fb[W-2:MAN_W] == EXP_ONES) && (w_fb[MAN_W-1:0] == '0);
    end

    // Signed keys make +0 and -0 identical and give sign-magnitude ordering.
    always_comb begin
        w_ka = w_fa[W-1] ? -$signed({1'b0, w_fa[W-2:0]}) : $signed({1'b0, w_fa[W-2:0]});
        w_kb = w_fb[W-1] ? -$signed({1'b0, w_fb[W-2:0]}) : $signed({1'b0, w_fb[W-2:0]});
        case (op_t'(bus.op))
            OP_EQ:   w_cmp = (w_ka == w_kb);
            OP_LT:   w_cmp = (w_ka <  w_kb);
            OP_GT:   w_cmp = (w_ka >  w_kb);
            OP_LE:   w_cmp = (w_ka <= w_kb);
            OP_GE:   w_cmp = (w_ka >= w_kb);
            default: w_cmp = 1'b0;
        endcase
    end

    always_comb begin
        w_fast     = 1'b1;
        w_fast_res = '0;
        w_fast_fl  = '0;
        case (op_t'(bus.op))
            OP_ADD, OP_SUB: begin
                w_fast = w_a_nan | w_b_nan | w_a_inf | w_b_inf;
                if (w_a_nan || w_b_nan) begin
                    w_fast_res = QNAN;
                    w_fast_fl  = FL_INV;
                end else if (w_a_inf && w_b_inf && (w_fa[W-1] != w_b_sign)) begin
                    w_fast_res = QNAN;
                    w_fast_fl  = FL_INV;
                end else if (w_a_inf) begin
                    w_fast_res = w_fa;
                end else if (w_b_inf) begin
                    w_fast_res = {w_b_sign, w_fb[W-2:0]};
                end
            end
            OP_MOV: w_fast_res = w_fa;
            default: begin
                if (w_a_nan || w_b_nan) w_fast_fl = FL_INV;
                else                    w_fast_res = {{(W-1){1'b0}}, w_cmp};
            end
        endcase
    end

    // Alignment datapath: x is the larger magnitude, y is shifted down to x's exponent.
    always_comb begin
        w_swap = r_b[W-2:0] > r_a[W-2:0];
        w_x    = w_swap ? r_b : r_a;
        w_y    = w_swap ? r_a : r_b;
        w_ex   = w_x[W-2:MAN_W];
        w_ey   = w_y[W-2:MAN_W];
        w_diff = w_ex - w_ey;
        w_mx   = {|w_ex, w_x[MAN_W-1:0]};
        w_my   = (32'(w_diff) > 32'(M)) ? '0 : ({|w_ey, w_y[MAN_W-1:0]} >> w_diff);
        w_sum  = r_sub ? ({1'b0, r_mx} - {1'b0, r_my}) : ({1'b0, r_mx} + {1'b0, r_my});
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    // NOTE: datapath registers are reset too, so an op aborted by reset leaves no stale operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_mx        <= '0;
            r_my        <= '0;
            r_man       <= '0;
            r_exp       <= '0;
            r_sx        <= 1'b0;
            r_sub       <= 1'b0;
            r_zero_sign <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        if (w_fast) begin
                            r_result    <= w_fast_res;
                            r_flags     <= w_fast_fl;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_a     <= w_fa;
                            r_b     <= {w_b_sign, w_fb[W-2:0]};
                            r_state <= S_ALIGN;
                        end
                    end
                end
                S_ALIGN: begin
                    r_mx        <= w_mx;
                    r_my        <= w_my;
                    r_exp       <= $signed({2'b00, w_ex});
                    r_sx        <= w_x[W-1];
                    r_sub       <= w_x[W-1] ^ w_y[W-1];
                    r_zero_sign <= w_x[W-1] & w_y[W-1];
                    r_state     <= S_SUM;
                end
                S_SUM: begin
                    if (w_sum[M]) begin
                        r_man <= w_sum[M:1];
                        r_exp <= r_exp + EXP_ONE;
                    end else begin
                        r_man <= w_sum[M-1:0];
                    end
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    if (r_man == '0) begin
                        r_result    <= {r_zero_sign, MAG_ZERO};
                        r_flags     <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_man[M-1]) begin
                        if (r_exp >= EXP_MAX) begin
                            r_result <= {r_sx, EXP_ONES, MAN_ZERO};
                            r_flags  <= FL_OVF;
                        end else if (r_exp < EXP_ONE) begin
                            r_result <= {r_sx, MAG_ZERO};
                            r_flags  <= FL_UNF;
                        end else begin
                            r_result <= {r_sx, r_exp[EXP_W-1:0], r_man[MAN_W-1:0]};
                            r_flags  <= '0;
                        end
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_man <= r_man << 1;
                        r_exp <= r_exp - EXP_ONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;
endmodule

// File: tb/tb_fpu_seq.sv
// Directed bench for fpu_seq: hand-computed single-precision vectors, latency,
// backpressure and mid-operation reset.
module tb_fpu_seq;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, EQ = 3'd2, LT = 3'd3,
                           GT  = 3'd4, LE  = 3'd5, GE = 3'd6, MOV = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   lat;

    always #5 clk = ~clk;

    fpu_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fpu_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present one op, time out_valid from the accept edge, check result/flags,
    // and when out_ready is high confirm the single-cycle DONE handshake.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic [2:0] exp_fl, input int exp_lat);
        int n;
        @(negedge clk);
        check({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'hFFFF_FFFF;
        n = 1;
        while (!bus.out_valid && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " result"}, bus.result, exp_res);
        check({tag, " flags"}, {29'd0, bus.flags}, {29'd0, exp_fl});
        if (bus.out_ready) begin
            @(posedge clk);
            #1;
            check({tag, " handshake"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = ADD;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        #2 rst_n = 1'b0;
        #1;
        check("reset in_ready/out_valid", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        check("reset result", bus.result, 32'd0);
        check("reset flags", {29'd0, bus.flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add 1+2",        ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 4);
        run_op("sub 1-0.75",     SUB, 32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 3'b000, 6);
        run_op("sub 1-1",        SUB, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3'b000, 4);
        run_op("add inf-inf",    ADD, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 3'b100, 1);
        run_op("add overflow",   ADD, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 3'b010, 4);
        run_op("add 3+-1",       ADD, 32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, 3'b000, 4);
        run_op("add 1+-2",       ADD, 32'h3F80_0000, 32'hC000_0000, 32'hBF80_0000, 3'b000, 5);
        run_op("add 2^24+1",     ADD, 32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 3'b000, 4);
        run_op("add -0+-0",      ADD, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 3'b000, 4);
        run_op("add denorm+-0",  ADD, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 3'b000, 4);
        run_op("sub underflow",  SUB, 32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 3'b001, 27);
        run_op("sub 1-nan",      SUB, 32'h3F80_0000, 32'h7FC0_0001, 32'h7FC0_0000, 3'b100, 1);
        run_op("sub 1-inf",      SUB, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 3'b000, 1);
        run_op("le -0,+0",       LE,  32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 3'b000, 1);
        run_op("lt -1,1",        LT,  32'hBF80_0000, 32'h3F80_0000, 32'h0000_0001, 3'b000, 1);
        run_op("eq nan,nan",     EQ,  32'h7FC0_0000, 32'h7FC0_0000, 32'h0000_0000, 3'b100, 1);
        run_op("gt 1,1",         GT,  32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3'b000, 1);
        run_op("ge 1,1",         GE,  32'h3F80_0000, 32'h3F80_0000, 32'h0000_0001, 3'b000, 1);
        run_op("gt 2,-3",        GT,  32'h4000_0000, 32'hC040_0000, 32'h0000_0001, 3'b000, 1);
        run_op("mov",            MOV, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 3'b000, 1);

        // Backpressure: result must hold while the consumer stalls.
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = ADD;
        bus.a        = 32'h3F80_0000;
        bus.b        = 32'h4000_0000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("stall latency", lat, 4);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall result", bus.result, 32'h4040_0000);
            check("stall flags", {29'd0, bus.flags}, 32'd0);
            check("stall valid/ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release valid/ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        run_op("back-to-back mov", MOV, 32'hC0FF_EE00, 32'h0000_0000, 32'hC0FF_EE00, 3'b000, 1);

        // Asynchronous reset while NORM is shifting.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = SUB;
        bus.a        = 32'h0080_0001;
        bus.b        = 32'h0080_0000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("mid-op valid/ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("async reset valid/ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        check("async reset result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post-reset add", ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
